br_resolve: RTL and testbench

- EX-stage branch resolution unit: the consuming end of the branch-prediction interface.
- Compares the prediction carried to EX (bp_to_ex_bus) against the actual branch outcome computed in EX.
- On a mismatch it drives br_bus {br_e, br_target} back to the predictor and the PC stage. br_e redirects fetch and also installs the BTB entry for ex_pc.
- Issues each correction exactly once per EX instruction, holding it until the PC stage accepts it.

---
 rtl/br_resolve_pkg.sv | 22 ++
 rtl/br_resolve_sat_cnt.sv | 16 +
 rtl/br_resolve.sv | 118 +++++++++++
 tb/tb_br_resolve.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/br_resolve_pkg.sv
// Shared types and constants for the EX-stage branch resolution unit.
// Holds the branch bus layout, stall vector encodings and the resolver state encodings.
package br_resolve_pkg;

   localparam int BR_WD   = 33;
   localparam int STALL_W = 6;

   localparam logic STOP    = 1'b1;
   localparam logic NO_STOP = 1'b0;

   typedef enum logic {
      BRR_IDLE = 1'b0,
      BRR_HOLD = 1'b1
   } brr_state_e;

   // {e, target}: bit 32 is the enable, bits 31:0 are the address.
   typedef struct packed {
      logic        e;
      logic [31:0] target;
   } br_bus_t;

endpackage

// File: rtl/br_resolve_sat_cnt.sv
// Saturating event counter, used for the optional branch performance counters.
module sat_cnt #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                    cnt <= '0;
      else if (inc && cnt != '1)   cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/br_resolve.sv
// EX-stage branch resolution: checks the carried prediction against the real outcome
// and issues one correction per EX instruction. BR_RESOLVE_PERF_EN adds perf counters.
module br_resolve
   import br_resolve_pkg::*;
#(
   parameter logic [31:0] DS_OFFSET = 32'd8,
   parameter logic [31:0] NB_OFFSET = 32'd4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [STALL_W-1:0] stall,
   input  logic               flush,
   input  logic               ex_valid,
   input  logic [31:0]        ex_pc,
   input  logic               ex_is_br,
   input  logic               ex_taken,
   input  logic [31:0]        ex_target,
   input  logic [BR_WD-1:0]   bp_to_ex_bus,
   output logic [BR_WD-1:0]   br_bus,
   output logic               br_busy
`ifdef BR_RESOLVE_PERF_EN
   ,
   output logic [31:0]        perf_br_cnt,
   output logic [31:0]        perf_mis_cnt
`endif
);

   brr_state_e  state, state_nxt;
   br_bus_t     bp, br;
   logic        done;
   logic [31:0] hold_tgt;
   logic [31:0] correct_pc;
   logic        resolve, m1, m2, m3, mis, issue;
   logic        pc_stop, ex_stop;
   logic        unused_stall;

   assign bp           = br_bus_t'(bp_to_ex_bus);
   assign pc_stop      = (stall[0] == STOP);
   assign ex_stop      = (stall[3] == STOP);
   assign unused_stall = ^{stall[5:4], stall[2:1]};

   // rst gates resolve so nothing leaks onto br_bus while reset is held.
   assign resolve = rst & ex_valid & ~flush & ~done & (state == BRR_IDLE);

   assign m1    = ex_is_br & ex_taken & (~bp.e | (bp.target != ex_target));
   assign m2    = ex_is_br & ~ex_taken & bp.e;
   assign m3    = ~ex_is_br & bp.e;
   assign mis   = m1 | m2 | m3;
   assign issue = resolve & mis;

   always_comb begin
      correct_pc = ex_target;
      if (m2)      correct_pc = ex_pc + DS_OFFSET;
      else if (m3) correct_pc = ex_pc + NB_OFFSET;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= BRR_IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         BRR_IDLE: if (issue && pc_stop) state_nxt = BRR_HOLD;
         BRR_HOLD: if (!pc_stop)         state_nxt = BRR_IDLE;
         default:                        state_nxt = BRR_IDLE;
      endcase
      if (flush) state_nxt = BRR_IDLE;
   end

   always_comb begin
      br      = '0;
      br_busy = 1'b0;
      if (!flush) begin
         case (state)
            BRR_HOLD: begin
               br      = '{e: 1'b1, target: hold_tgt};
               br_busy = 1'b1;
            end
            default: if (issue) br = '{e: 1'b1, target: correct_pc};
         endcase
      end
   end

   assign br_bus = br;

   // done blocks a stalled EX instruction from redirecting again; an issue wins over the clear.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)          done <= 1'b0;
      else if (flush)    done <= 1'b0;
      else if (issue)    done <= 1'b1;
      else if (!ex_stop) done <= 1'b0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                  hold_tgt <= '0;
      else if (flush)            hold_tgt <= '0;
      else if (issue && pc_stop) hold_tgt <= correct_pc;
   end

`ifdef BR_RESOLVE_PERF_EN
   sat_cnt #(.W(32)) u_br_cnt (
      .clk (clk),
      .rst (rst),
      .inc (resolve & ex_is_br),
      .cnt (perf_br_cnt)
   );

   sat_cnt #(.W(32)) u_mis_cnt (
      .clk (clk),
      .rst (rst),
      .inc (issue),
      .cnt (perf_mis_cnt)
   );
`endif

endmodule

// File: tb/tb_br_resolve.sv
// Directed scoreboard bench for br_resolve: the driver queues per-cycle expectations,
// the monitor pops and compares them on the falling edge.
module tb_br_resolve;
   import br_resolve_pkg::*;

   logic               clk = 1'b0;
   logic               rst = 1'b0;
   logic [STALL_W-1:0] stall = '0;
   logic               flush = 1'b0;
   logic               ex_valid = 1'b0;
   logic [31:0]        ex_pc = '0;
   logic               ex_is_br = 1'b0;
   logic               ex_taken = 1'b0;
   logic [31:0]        ex_target = '0;
   logic [BR_WD-1:0]   bp_to_ex_bus = '0;
   logic [BR_WD-1:0]   br_bus;
   logic               br_busy;
`ifdef BR_RESOLVE_PERF_EN
   logic [31:0]        perf_br_cnt, perf_mis_cnt;
`endif

   br_resolve dut (
      .clk          (clk),
      .rst          (rst),
      .stall        (stall),
      .flush        (flush),
      .ex_valid     (ex_valid),
      .ex_pc        (ex_pc),
      .ex_is_br     (ex_is_br),
      .ex_taken     (ex_taken),
      .ex_target    (ex_target),
      .bp_to_ex_bus (bp_to_ex_bus),
      .br_bus       (br_bus),
      .br_busy      (br_busy)
`ifdef BR_RESOLVE_PERF_EN
      ,
      .perf_br_cnt  (perf_br_cnt),
      .perf_mis_cnt (perf_mis_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [BR_WD-1:0] bus;
      logic             busy;
      string            name;
   } exp_t;

   exp_t q[$];
   int   n_chk  = 0;
   int   n_pass = 0;

   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         n_chk++;
         if (br_bus === e.bus) n_pass++;
         else $display("FAIL %s.br_bus got=%h exp=%h", e.name, br_bus, e.bus);
         n_chk++;
         if (br_busy === e.busy) n_pass++;
         else $display("FAIL %s.br_busy got=%b exp=%b", e.name, br_busy, e.busy);
      end
   end

   // Drive one cycle of inputs at posedge+1 and queue what the outputs must be in that cycle.
   task automatic step(input logic r, input logic v, input logic [31:0] pc,
                       input logic isbr, input logic tk, input logic [31:0] tgt,
                       input logic bpe, input logic [31:0] bpt,
                       input logic st0, input logic st3, input logic fl,
                       input logic exp_e, input logic [31:0] exp_tgt, input logic exp_busy,
                       input string name);
      exp_t e;
      rst          = r;
      ex_valid     = v;
      ex_pc        = pc;
      ex_is_br     = isbr;
      ex_taken     = tk;
      ex_target    = tgt;
      bp_to_ex_bus = {bpe, bpt};
      stall        = '0;
      stall[0]     = st0;
      stall[3]     = st3;
      flush        = fl;
      e.bus  = {exp_e, exp_tgt};
      e.busy = exp_busy;
      e.name = name;
      q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input string name);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, name);
   endtask

   initial begin
      @(posedge clk);
      #1;
      // reset with a live mismatching instruction present: outputs must stay 0
      step(0, 1, 32'h100, 1, 1, 32'h200, 0, 0, 0, 0, 0, 0, 32'h0, 0, "reset0");
      step(0, 1, 32'h100, 1, 1, 32'h200, 0, 0, 0, 0, 0, 0, 32'h0, 0, "reset1");
      idle("post_reset");

      step(1, 1, 32'h100, 1, 1, 32'h200, 1, 32'h200, 0, 0, 0, 0, 32'h0, 0, "nomis0");
      step(1, 1, 32'h100, 1, 1, 32'h200, 1, 32'h200, 0, 0, 0, 0, 32'h0, 0, "nomis1");
      idle("nomis_idle");

      // cold taken branch, EX stalled: exactly one pulse
      step(1, 1, 32'h100, 1, 1, 32'h200, 0, 0, 0, 1, 0, 1, 32'h200, 0, "cold_st0");
      step(1, 1, 32'h100, 1, 1, 32'h200, 0, 0, 0, 1, 0, 0, 32'h0, 0, "cold_st1");
      step(1, 1, 32'h100, 1, 1, 32'h200, 0, 0, 0, 1, 0, 0, 32'h0, 0, "cold_st2");
      step(1, 1, 32'h100, 1, 1, 32'h200, 0, 0, 0, 0, 0, 0, 32'h0, 0, "cold_st3");
      idle("cold_idle");
      step(1, 1, 32'h100, 1, 1, 32'h200, 0, 0, 0, 0, 0, 1, 32'h200, 0, "cold");
      idle("cold_after");

      step(1, 1, 32'h100, 1, 1, 32'h200, 1, 32'h300, 0, 0, 0, 1, 32'h200, 0, "wrong_tgt");
      idle("wrong_tgt_after");

      step(1, 1, 32'hBFC0_0010, 1, 0, 32'h0, 1, 32'h400, 0, 0, 0, 1, 32'hBFC0_0018, 0, "m2");
      idle("m2_after");

      step(1, 1, 32'hFFFF_FFFC, 0, 0, 32'h0, 1, 32'h1234, 0, 0, 0, 1, 32'h0, 0, "m3_wrap");
      idle("m3_after");

      // HOLD for 4 stop cycles; a later mismatch is ignored until back in IDLE
      step(1, 1, 32'h100, 1, 1, 32'h200, 0, 0, 1, 1, 0, 1, 32'h200, 0, "hold_a");
      step(1, 1, 32'h500, 0, 0, 32'h0, 1, 32'h777, 1, 1, 0, 1, 32'h200, 1, "hold_b");
      step(1, 1, 32'h500, 0, 0, 32'h0, 1, 32'h777, 1, 1, 0, 1, 32'h200, 1, "hold_c");
      step(1, 1, 32'h500, 0, 0, 32'h0, 1, 32'h777, 1, 1, 0, 1, 32'h200, 1, "hold_d");
      step(1, 1, 32'h500, 0, 0, 32'h0, 1, 32'h777, 0, 0, 0, 1, 32'h200, 1, "hold_e");
      step(1, 1, 32'h500, 0, 0, 32'h0, 1, 32'h777, 0, 0, 0, 1, 32'h504, 0, "hold_next");
      idle("hold_idle");

      step(1, 1, 32'h100, 1, 1, 32'h200, 0, 0, 0, 0, 1, 0, 32'h0, 0, "flush_mis");
      idle("flush_mis_after");

      step(1, 1, 32'h100, 1, 1, 32'h200, 0, 0, 1, 1, 0, 1, 32'h200, 0, "fhold_a");
      step(1, 1, 32'h100, 1, 1, 32'h200, 0, 0, 1, 1, 0, 1, 32'h200, 1, "fhold_b");
      step(1, 1, 32'h100, 1, 1, 32'h200, 0, 0, 1, 1, 1, 0, 32'h0, 0, "fhold_flush");
      step(1, 0, 32'h0, 0, 0, 32'h0, 0, 0, 1, 0, 0, 0, 32'h0, 0, "fhold_after");

`ifdef BR_RESOLVE_PERF_EN
      n_chk++;
      if (perf_br_cnt === 32'd8) n_pass++;
      else $display("FAIL perf_br_cnt got=%0d exp=8", perf_br_cnt);
      n_chk++;
      if (perf_mis_cnt === 32'd8) n_pass++;
      else $display("FAIL perf_mis_cnt got=%0d exp=8", perf_mis_cnt);
`endif

      // async reset in the middle of HOLD
      step(1, 1, 32'h100, 1, 1, 32'h200, 0, 0, 1, 1, 0, 1, 32'h200, 0, "rhold_a");
      step(1, 1, 32'h100, 1, 1, 32'h200, 0, 0, 1, 1, 0, 1, 32'h200, 1, "rhold_b");
      step(0, 1, 32'h100, 1, 1, 32'h200, 0, 0, 1, 1, 0, 0, 32'h0, 0, "rhold_rst");
      idle("rhold_after");

      begin
         int guard = 0;
         while (q.size() > 0 && guard < 10) begin
            @(negedge clk);
            guard++;
         end
         #1;
         if (q.size() > 0) begin
            n_chk++;
            $display("FAIL drain pending=%0d exp=0", q.size());
         end
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
